// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the fetch / load-store memory arbiter.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates instruction fetch and load/store onto one single-ported memory, one access in flight.
// Latency: request seen in IDLE -> gnt next cycle -> rvalid/done MEM_LAT+2 cycles after the request.
// Backpressure: requesters hold req until gnt; requests are ignored while a transaction is in flight.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MEM_LAT - 1);
    localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);

    state_t           state;
    owner_t           owner;
    logic             lat_we;
    logic [CNT_W-1:0] wait_cnt;
    logic [SC_W-1:0]  starve_cnt;
    logic             pick_if;

    // Load/store has priority; fetch only wins alone or once it has lost STARVE_MAX times in a row.
    always_comb begin
        pick_if = if_req && (!ls_req || starve_cnt == STARVE_TOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_done    <= 1'b0;
            ls_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        state  <= ST_ISSUE;
                        mem_en <= 1'b1;
                        if (pick_if) begin
                            owner      <= OWN_IF;
                            lat_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            if_gnt     <= 1'b1;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWN_LS;
                            lat_we    <= ls_we;
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            ls_gnt    <= 1'b1;
                            if (if_req && starve_cnt != STARVE_TOP) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= CNT_W'(1);
                    state    <= (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // Read data is valid on mem_rdata during this cycle; stores leave ls_rdata alone.
                    state <= ST_IDLE;
                    if (owner == OWN_IF) begin
                        if_rdata  <= mem_rdata;
                        if_rvalid <= 1'b1;
                    end else begin
                        ls_done <= 1'b1;
                        if (!lat_we) begin
                            ls_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: checks two mem_arbiter instances (MEM_LAT 1 and 3) against a transaction-timeline model.
// Latency: model expects gnt at request+1 and rvalid/done at request+MEM_LAT+2.
// Backpressure: stimulus holds each request until its grant, then drops it.
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        ls_req    [2];
    logic        ls_we     [2];
    logic [31:0] ls_addr   [2];
    logic [31:0] ls_wdata  [2];
    logic        ls_gnt    [2];
    logic        ls_done   [2];
    logic [31:0] ls_rdata  [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(SMAX)
        ) dut (
            .clk(clk), .rst(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]),
            .ls_gnt(ls_gnt[g]), .ls_done(ls_done[g]), .ls_rdata(ls_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got 0x%08h, want 0x%08h", nm, k, cyc, act, exp);
        end
    endtask

    // Memory image shared by the responder and the model; key is {instance, address}.
    logic [31:0] mem_img [logic [32:0]];

    function automatic logic [31:0] mem_rd(input int k, input logic [31:0] a);
        logic [32:0] key;
        key = {k[0], a};
        if (mem_img.exists(key)) return mem_img[key];
        return a ^ 32'h5A5A_0000;
    endfunction

    int          due     [2] = '{-1, -1};
    logic [31:0] due_dat [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] === 1'b1) begin
                due_dat[k] = mem_rd(k, mem_addr[k]);
                if (mem_we[k] === 1'b1) mem_img[{k[0], mem_addr[k]}] = mem_wdata[k];
                due[k] = cyc + lat_of(k);
            end
        end
    end

    // Data is only correct in the one cycle it is due; junk otherwise.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = (cyc == due[k]) ? due_dat[k] : (32'hBAD0_0000 ^ 32'(cyc));
        end
    end

    bit          m_live  [2] = '{0, 0};
    int          m_issue [2], m_done [2], m_free [2], m_starve [2];
    bit          m_ls    [2], m_we   [2];
    logic [31:0] m_addr  [2], m_wdata [2], m_paddr [2], m_pwdata [2], m_pdata [2];
    logic [31:0] m_ifd   [2], m_lsd   [2];
    int          en_cnt  [2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          b2b     [2] = '{0, 0};
    bit          prev_en [2] = '{0, 0};
    bit          rec     [2] = '{0, 0};
    string       gseq    [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit e_en, e_dn, pick_if;
            if (m_live[k]) begin
                if (cyc == m_issue[k]) begin
                    m_addr[k]  = m_paddr[k];
                    m_wdata[k] = m_pwdata[k];
                end
                e_en = (cyc == m_issue[k]);
                e_dn = (cyc == m_done[k]);
                if (e_dn && !m_ls[k]) m_ifd[k] = m_pdata[k];
                if (e_dn && m_ls[k] && !m_we[k]) m_lsd[k] = m_pdata[k];
                chk("mem_en",    k, mem_en[k],    e_en);
                chk("mem_we",    k, mem_we[k],    e_en && m_we[k]);
                chk("if_gnt",    k, if_gnt[k],    e_en && !m_ls[k]);
                chk("ls_gnt",    k, ls_gnt[k],    e_en && m_ls[k]);
                chk("if_rvalid", k, if_rvalid[k], e_dn && !m_ls[k]);
                chk("ls_done",   k, ls_done[k],   e_dn && m_ls[k]);
                chk("mem_addr",  k, mem_addr[k],  m_addr[k]);
                chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
                chk("if_rdata",  k, if_rdata[k],  m_ifd[k]);
                chk("ls_rdata",  k, ls_rdata[k],  m_lsd[k]);
            end
            if (mem_en[k] === 1'b1) en_cnt[k]++;
            if (mem_en[k] === 1'b1 && prev_en[k]) b2b[k]++;
            prev_en[k] = (mem_en[k] === 1'b1);
            if (ls_done[k] === 1'b1) done_cnt[k]++;
            if (rec[k] && if_gnt[k] === 1'b1) gseq[k] = {gseq[k], "I"};
            if (rec[k] && ls_gnt[k] === 1'b1) gseq[k] = {gseq[k], "L"};

            if (rst[k]) begin
                m_live[k] = 1; m_issue[k] = -1; m_done[k] = -1; m_free[k] = 0; m_starve[k] = 0;
                m_addr[k] = '0; m_wdata[k] = '0; m_ifd[k] = '0; m_lsd[k] = '0;
            end else if (m_live[k] && cyc >= m_free[k] && (if_req[k] || ls_req[k])) begin
                pick_if = if_req[k] && (!ls_req[k] || m_starve[k] == SMAX);
                if (pick_if) begin
                    m_starve[k] = 0;
                    m_ls[k] = 0; m_we[k] = 0;
                    m_paddr[k] = if_addr[k]; m_pwdata[k] = '0;
                    m_pdata[k] = mem_rd(k, if_addr[k]);
                end else begin
                    if (if_req[k]) m_starve[k] = (m_starve[k] < SMAX) ? m_starve[k] + 1 : SMAX;
                    m_ls[k] = 1; m_we[k] = ls_we[k];
                    m_paddr[k] = ls_addr[k]; m_pwdata[k] = ls_wdata[k];
                    m_pdata[k] = mem_rd(k, ls_addr[k]);
                end
                m_issue[k] = cyc + 1;
                m_done[k]  = cyc + lat_of(k) + 2;
                m_free[k]  = m_done[k];
            end
        end
    end

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int k, input bit is_ls, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, output int t_req, output int t_gnt,
                          output int t_done, output logic g_we, output logic [31:0] g_addr,
                          output logic [31:0] g_wd);
        t_gnt = -1; t_done = -1; g_we = 1'b0; g_addr = '0; g_wd = '0;
        if (is_ls) begin
            ls_req[k] = 1'b1; ls_we[k] = we; ls_addr[k] = a; ls_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = a;
        end
        t_req = cyc;
        for (int i = 0; i < 20 && t_gnt < 0; i++) begin
            @(negedge clk);
            if ((is_ls ? ls_gnt[k] : if_gnt[k]) === 1'b1) begin
                t_gnt = cyc; g_we = mem_we[k]; g_addr = mem_addr[k]; g_wd = mem_wdata[k];
            end
        end
        chk("gnt_seen", k, 32'(t_gnt >= 0), 32'd1);
        wait_pos();
        if_req[k] = 1'b0;
        ls_req[k] = 1'b0;
        for (int i = 0; i < 20 && t_done < 0; i++) begin
            @(negedge clk);
            if ((is_ls ? ls_done[k] : if_rvalid[k]) === 1'b1) t_done = cyc;
        end
        chk("resp_seen", k, 32'(t_done >= 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int tr, tg, td, e0, d0, g;
        logic gw;
        logic [31:0] ga, gd;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; ls_req[k] = 1'b0;
            ls_we[k] = 1'b0; ls_addr[k] = '0; ls_wdata[k] = '0; mem_rdata[k] = '0;
            gseq[k] = "";
        end
        mem_img[{1'b0, 32'h0000_0010}] = 32'h0010_0093;
        mem_img[{1'b0, 32'h0000_0200}] = 32'hCAFE_0001;
        mem_img[{1'b1, 32'h0000_0040}] = 32'h1234_5678;
        repeat (2) wait_pos();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        wait_pos();

        // Fetch only, MEM_LAT=1
        do_req(0, 0, 0, 32'h0000_0010, '0, tr, tg, td, gw, ga, gd);
        chk("fetch_gnt_lat", 0, tg - tr, 1);
        chk("fetch_rvalid_lat", 0, td - tr, 3);
        chk("fetch_rdata", 0, if_rdata[0], 32'h0010_0093);
        wait_pos();

        // Load, then store leaves ls_rdata alone, then load back the stored word
        do_req(0, 1, 0, 32'h0000_0200, '0, tr, tg, td, gw, ga, gd);
        chk("load_rdata", 0, ls_rdata[0], 32'hCAFE_0001);
        wait_pos();
        e0 = en_cnt[0];
        d0 = done_cnt[0];
        do_req(0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, tr, tg, td, gw, ga, gd);
        repeat (4) wait_pos();
        chk("store_mem_en_count", 0, en_cnt[0] - e0, 1);
        chk("store_done_count", 0, done_cnt[0] - d0, 1);
        chk("store_mem_we", 0, gw, 1);
        chk("store_addr", 0, ga, 32'h0000_0100);
        chk("store_wdata", 0, gd, 32'hDEAD_BEEF);
        chk("store_ls_rdata_kept", 0, ls_rdata[0], 32'hCAFE_0001);
        do_req(0, 1, 0, 32'h0000_0100, '0, tr, tg, td, gw, ga, gd);
        chk("load_after_store", 0, ls_rdata[0], 32'hDEAD_BEEF);
        wait_pos();

        // Both held continuously: starvation guard
        e0 = b2b[0];
        rec[0] = 1'b1;
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0300;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h0000_0304;
        repeat (40) wait_pos();
        if_req[0] = 1'b0;
        ls_req[0] = 1'b0;
        repeat (6) wait_pos();
        rec[0] = 1'b0;
        chk("grant_order", 0, 32'(gseq[0].substr(0, 9) == "LLLLILLLLI"), 32'd1);
        chk("no_b2b_mem_en", 0, b2b[0] - e0, 0);

        // MEM_LAT=3 load and fetch
        do_req(1, 1, 0, 32'h0000_0040, '0, tr, tg, td, gw, ga, gd);
        chk("lat3_load_lat", 1, td - tr, 5);
        chk("lat3_load_rdata", 1, ls_rdata[1], 32'h1234_5678);
        wait_pos();
        do_req(1, 0, 0, 32'h0000_0044, '0, tr, tg, td, gw, ga, gd);
        chk("lat3_fetch_lat", 1, td - tr, 5);
        chk("lat3_fetch_rdata", 1, if_rdata[1], 32'h5A5A_0044);
        wait_pos();

        // Reset while in WAIT aborts the load
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h0000_0048;
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk);
            if (ls_gnt[1] === 1'b1) g = cyc;
        end
        chk("abort_gnt_seen", 1, 32'(g >= 0), 32'd1);
        wait_pos();
        ls_req[1] = 1'b0;
        rst[1] = 1'b1;
        e0 = en_cnt[1];
        d0 = done_cnt[1];
        wait_pos();
        rst[1] = 1'b0;
        @(negedge clk);
        chk("rst_ls_rdata", 1, ls_rdata[1], 32'h0);
        chk("rst_if_rdata", 1, if_rdata[1], 32'h0);
        chk("rst_mem_addr", 1, mem_addr[1], 32'h0);
        chk("rst_mem_en", 1, mem_en[1], 0);
        chk("rst_ls_done", 1, ls_done[1], 0);
        repeat (8) wait_pos();
        chk("abort_no_done", 1, done_cnt[1] - d0, 0);
        chk("abort_no_mem_en", 1, en_cnt[1] - e0, 0);
        do_req(1, 1, 0, 32'h0000_004C, '0, tr, tg, td, gw, ga, gd);
        chk("post_rst_lat", 1, td - tr, 5);
        chk("post_rst_rdata", 1, ls_rdata[1], 32'h5A5A_004C);

        repeat (4) wait_pos();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, cycles from issue to read data valid; legal range 1..4.
REQ-004 SHALL have parameter STARVE_MAX, default 4, consecutive fetch losses before fetch is forced to win.
REQ-005 SHALL have ports, one clock and a synchronous active-high reset:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  if_req  in  1  fetch request, held until if_gnt
  if_addr  in  ADDR_W  fetch address
  if_gnt  out  1  fetch issued this cycle
  if_rvalid  out  1  fetch data valid pulse
  if_rdata  out  DATA_W  fetch data
  ls_req  in  1  load/store request, held until ls_gnt
  ls_we  in  1  1 = store
  ls_addr  in  ADDR_W  load/store address
  ls_wdata  in  DATA_W  store data
  ls_gnt  out  1  load/store issued this cycle
  ls_done  out  1  load/store completion pulse (loads and stores)
  ls_rdata  out  DATA_W  load data
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one transaction outstanding at a time.
REQ-007 In IDLE, with any request high, SHALL select an owner, latch its addr/we/wdata, and go to ISSUE next cycle; no request -> stay IDLE.
REQ-008 Selection: ls only -> ls; if only -> if; both -> ls, unless starve count == STARVE_MAX, then if.
REQ-009 Starve count SHALL increment (saturating at STARVE_MAX) when both requests are high and ls wins; SHALL clear to 0 whenever if wins.
REQ-010 In ISSUE (exactly one cycle), SHALL assert mem_en and the owner's gnt, drive mem_addr/mem_we/mem_wdata from latched values; mem_we = 0 for fetch.
REQ-011 WAIT SHALL last MEM_LAT-1 cycles (zero when MEM_LAT = 1); RESP occurs exactly MEM_LAT cycles after ISSUE.
REQ-012 In RESP, SHALL sample mem_rdata into the owner's rdata register and pulse the owner's rvalid/done for one cycle the following cycle... no: pulse coincides with rdata update, i.e., rvalid/done and new rdata are visible in the cycle after RESP sampling; total request-to-data latency = MEM_LAT + 2 cycles.
REQ-013 Store completion SHALL pulse ls_done with ls_rdata unchanged.
REQ-014 if_rdata/ls_rdata SHALL hold their last value until the next response for that requester.
REQ-015 Outside ISSUE, mem_en, mem_we, if_gnt, ls_gnt SHALL be 0; mem_addr/mem_wdata hold latched values.
REQ-016 Requests arriving while not in IDLE SHALL be ignored until IDLE; a request still high in the first IDLE cycle is a new request.
REQ-017 Request changes after latching in IDLE SHALL NOT affect the in-flight transaction.

Reset
REQ-018 rst SHALL force IDLE, starve count 0, all outputs 0, rdata registers 0, within the same edge.
REQ-019 Reset during ISSUE/WAIT/RESP SHALL abort the transaction: no rvalid/done pulse afterward, no further mem_en.

Structure
REQ-020 Package cpu_mem_pkg SHALL hold the FSM state enum, owner enum (OWN_IF, OWN_LS), and default parameter constants.
REQ-021 No sub-module; single module, latency counter width clog2(MEM_LAT+1).

Verification
REQ-022 Fetch only, MEM_LAT=1, if_addr=0x0000_0010, mem_rdata=0x0010_0093 -> if_gnt cycle 2, if_rvalid cycle 4, if_rdata=0x0010_0093.
REQ-023 Store, ls_addr=0x0000_0100, ls_wdata=0xDEAD_BEEF -> one cycle mem_en=1, mem_we=1, those addr/data; ls_done once; ls_rdata unchanged.
REQ-024 Both requests continuously held, STARVE_MAX=4 -> grant order ls,ls,ls,ls,if, repeating; no back-to-back mem_en.
REQ-025 MEM_LAT=3, load -> ls_done exactly 5 cycles after request first seen in IDLE; ls_rdata equals mem_rdata sampled 3 cycles after mem_en.
REQ-026 rst asserted in WAIT -> next cycle all outputs 0, state IDLE, no done pulse; request after rst release serviced normally.
